// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 7-segment display driver.
// A prescaler divides clk into digit slots. Each slot opens with a short
// anti-ghost window in which every digit is off. Shadow registers hold the
// displayed data, and all outputs are registered. Segment, decimal point and
// digit select are all active-low.
module seg7_scan_driver #(
   parameter int N_DIGITS  = 4,
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 16,
   parameter int BLINK_DIV = 64,
   parameter int HEX_EN    = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] bcd_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic [N_DIGITS-1:0]   blank_mask,
   input  logic [N_DIGITS-1:0]   blink_mask,
   input  logic                  lzs_en,
   output logic [6:0]            seg_out,
   output logic                  dp_out,
   output logic [N_DIGITS-1:0]   dig_sel
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int SW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
   localparam logic [SW-1:0] SLOT_LAST  = SW'(N_DIGITS - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);
   localparam logic [6:0]    SEG_DARK   = 7'b1111111;
   localparam logic          HEX_ON     = (HEX_EN != 0);

   // Segment pattern for one code, bits g..a (bit 6 = g), active-low
   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = HEX_ON ? 7'b0001000 : SEG_DARK;
         4'hB:    seg = HEX_ON ? 7'b0000011 : SEG_DARK;
         4'hC:    seg = HEX_ON ? 7'b1000110 : SEG_DARK;
         4'hD:    seg = HEX_ON ? 7'b0100001 : SEG_DARK;
         4'hE:    seg = HEX_ON ? 7'b0000110 : SEG_DARK;
         4'hF:    seg = HEX_ON ? 7'b0001110 : SEG_DARK;
         default: seg = SEG_DARK;
      endcase
      return seg;
   endfunction

   logic [PW-1:0]           presc_r;
   logic [SW-1:0]           slot_r;
   logic [FW-1:0]           frame_r;
   logic                    blink_r;

   logic [4*N_DIGITS-1:0]   bcd_sh_r;
   logic [N_DIGITS-1:0]     dp_sh_r;
   logic [N_DIGITS-1:0]     blank_sh_r;
   logic [N_DIGITS-1:0]     blink_sh_r;

   logic                    wrap_s;
   logic                    frame_tick_s;
   logic [3:0]              code_s [N_DIGITS];
   logic [6:0]              digit_seg_s [N_DIGITS];
   logic [N_DIGITS-1:0]     dark_s;
   logic                    zero_above_s;
   logic                    lzs_hit_s;
   logic [6:0]              sel_seg_s;
   logic                    sel_dp_s;
   logic                    sel_dark_s;
   logic [6:0]              seg_nxt_s;
   logic                    dp_nxt_s;
   logic [N_DIGITS-1:0]     dig_nxt_s;

   assign wrap_s       = (presc_r == PRESC_LAST);
   assign frame_tick_s = wrap_s && (slot_r == SLOT_LAST);

   // Scan timebase: prescaler, slot index, frame counter and blink phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_r <= {PW{1'b0}};
         slot_r  <= {SW{1'b0}};
         frame_r <= {FW{1'b0}};
         blink_r <= 1'b0;
      end else begin
         if (wrap_s) begin
            presc_r <= {PW{1'b0}};
            if (slot_r == SLOT_LAST) begin
               slot_r <= {SW{1'b0}};
            end else begin
               slot_r <= slot_r + SW'(1'b1);
            end
         end else begin
            presc_r <= presc_r + PW'(1'b1);
         end
         if (frame_tick_s) begin
            if (frame_r == FRAME_LAST) begin
               frame_r <= {FW{1'b0}};
               blink_r <= ~blink_r;
            end else begin
               frame_r <= frame_r + FW'(1'b1);
            end
         end
      end
   end

   // Shadow registers; a held load strobe keeps re-capturing so the last cycle wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_sh_r   <= {(4*N_DIGITS){1'b0}};
         dp_sh_r    <= {N_DIGITS{1'b0}};
         blank_sh_r <= {N_DIGITS{1'b0}};
         blink_sh_r <= {N_DIGITS{1'b0}};
      end else if (load) begin
         bcd_sh_r   <= bcd_in;
         dp_sh_r    <= dp_in;
         blank_sh_r <= blank_mask;
         blink_sh_r <= blink_mask;
      end
   end

   // Per-digit decode and darkness; walk from the top digit to track leading zeros
   always_comb begin
      zero_above_s = 1'b1;
      lzs_hit_s    = 1'b0;
      dark_s       = {N_DIGITS{1'b0}};
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         code_s[k]      = bcd_sh_r[4*k +: 4];
         digit_seg_s[k] = seg_decode(code_s[k]);
         lzs_hit_s      = lzs_en && zero_above_s && (code_s[k] == 4'h0) && (k > 0);
         dark_s[k]      = blank_sh_r[k] || (blink_sh_r[k] && blink_r) || lzs_hit_s;
         zero_above_s   = zero_above_s && (code_s[k] == 4'h0);
      end
   end

   // Pick the digit addressed by the current slot
   always_comb begin
      sel_seg_s  = SEG_DARK;
      sel_dp_s   = 1'b0;
      sel_dark_s = 1'b1;
      for (int k = 0; k < N_DIGITS; k++) begin
         sel_seg_s  = (slot_r == SW'(k)) ? digit_seg_s[k] : sel_seg_s;
         sel_dp_s   = (slot_r == SW'(k)) ? dp_sh_r[k]     : sel_dp_s;
         sel_dark_s = (slot_r == SW'(k)) ? dark_s[k]      : sel_dark_s;
      end
   end

   // Next output values: enable gate, anti-ghost window, dark-digit override
   always_comb begin
      seg_nxt_s = SEG_DARK;
      dp_nxt_s  = 1'b1;
      dig_nxt_s = {N_DIGITS{1'b1}};
      if (enable) begin
         if (presc_r >= BLANK_END) begin
            dig_nxt_s = ~(N_DIGITS'(1'b1) << slot_r);
         end else begin
            dig_nxt_s = {N_DIGITS{1'b1}};
         end
         if (sel_dark_s) begin
            seg_nxt_s = SEG_DARK;
            dp_nxt_s  = 1'b1;
         end else begin
            seg_nxt_s = sel_seg_s;
            dp_nxt_s  = ~sel_dp_s;
         end
      end else begin
         seg_nxt_s = SEG_DARK;
         dp_nxt_s  = 1'b1;
         dig_nxt_s = {N_DIGITS{1'b1}};
      end
   end

   // Output registers, inactive while in reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_out <= SEG_DARK;
         dp_out  <= 1'b1;
         dig_sel <= {N_DIGITS{1'b1}};
      end else begin
         seg_out <= seg_nxt_s;
         dp_out  <= dp_nxt_s;
         dig_sel <= dig_nxt_s;
      end
   end

endmodule
